time_display_ctrl: RTL and testbench

//  Consumer of the 2-bit display-mode state produced by the mode FSM.

---
 rtl/time_display_ctrl_pkg.sv | 54 +++++
 rtl/bcd_mod_counter.sv | 43 ++++
 rtl/time_display_ctrl.sv | 141 ++++++++++++++
 tb/tb_time_display_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/time_display_ctrl_pkg.sv
// Shared display-mode codes, BCD constants and hour-format helpers for the
// time-of-day display controller.
package time_display_ctrl_pkg;

  typedef enum logic [1:0] {
    STAT_12_ONE = 2'b00,
    STAT_12_TWO = 2'b01,
    STAT_24_ONE = 2'b10,
    STAT_24_TWO = 2'b11
  } disp_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  // Maps a 00-23 BCD hour onto the 1-12 clock face without a binary detour.
  function automatic bcd_pair_t hour_to_12h(input bcd_pair_t hr24);
    bcd_pair_t hr12;
    hr12 = hr24;
    unique case (hr24.tens)
      4'd0: begin
        if (hr24.ones == 4'd0) begin
          hr12.tens = 4'd1;
          hr12.ones = 4'd2;
        end
      end
      4'd1: begin
        if (hr24.ones >= 4'd3) begin
          hr12.tens = 4'd0;
          hr12.ones = hr24.ones - 4'd2;
        end
      end
      4'd2: begin
        if (hr24.ones <= 4'd1) begin
          hr12.tens = 4'd0;
          hr12.ones = hr24.ones + 4'd8;
        end else begin
          hr12.tens = 4'd1;
          hr12.ones = hr24.ones - 4'd2;
        end
      end
      default: hr12 = hr24;
    endcase
    return hr12;
  endfunction

  function automatic logic hour_is_pm(input bcd_pair_t hr24);
    return (hr24.tens >= 4'd2) || (hr24.tens == 4'd1 && hr24.ones >= 4'd2);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps after MAX_TENS:MAX_ONES; carry flags the
// enabled step that wraps so the next stage can chain on it.
module bcd_mod_counter
  import time_display_ctrl_pkg::*;
#(
  parameter logic [3:0] MAX_TENS = 4'd5,
  parameter logic [3:0] MAX_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_on_wrap,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic at_max;

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign carry  = en & at_max;

  // With clr_on_wrap low the counter parks at its maximum instead of rolling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (en) begin
      if (at_max) begin
        if (clr_on_wrap) begin
          tens <= 4'd0;
          ones <= 4'd0;
        end
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_display_ctrl.sv
// Time-of-day keeper with 12/24 h formatting and HH:MM / MM:SS page select,
// driving a registered 4-digit BCD bus and PM flag to the 7-segment scanner.
module time_display_ctrl
  import time_display_ctrl_pkg::*;
#(
  parameter logic [3:0] BLANK_CODE    = BCD_BLANK,
  parameter bit         LEADING_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic       tick,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       pm
);

  logic        adjust;
  logic        sec_en;
  logic        min_en;
  logic        hr_en;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic        sec_carry;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic        min_carry;
  logic [3:0]  hr_tens;
  logic [3:0]  hr_ones;
  logic        hr_wrap_unused;
  bcd_pair_t   sec_bcd;
  bcd_pair_t   min_bcd;
  bcd_pair_t   hr_bcd;
  bcd_pair_t   hr12_bcd;
  bcd_pair_t   hr_shown;
  disp_state_e mode;
  logic        twelve_hr;
  logic        page_two;
  logic [15:0] digits_next;
  logic        pm_next;

  // Manual adjust swallows a coincident tick, and a minute bump never ripples into the hour.
  assign adjust = inc_hr | inc_min;
  assign sec_en = tick & ~adjust;
  assign min_en = inc_min | sec_carry;
  assign hr_en  = inc_hr | (min_carry & ~inc_min);

  bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_ONES(4'd9)) u_sec (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (sec_en),
    .clr_on_wrap (1'b1),
    .tens        (sec_tens),
    .ones        (sec_ones),
    .carry       (sec_carry)
  );

  bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_ONES(4'd9)) u_min (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (min_en),
    .clr_on_wrap (1'b1),
    .tens        (min_tens),
    .ones        (min_ones),
    .carry       (min_carry)
  );

  bcd_mod_counter #(.MAX_TENS(4'd2), .MAX_ONES(4'd3)) u_hr (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (hr_en),
    .clr_on_wrap (1'b1),
    .tens        (hr_tens),
    .ones        (hr_ones),
    .carry       (hr_wrap_unused)
  );

  assign sec_bcd  = '{tens: sec_tens, ones: sec_ones};
  assign min_bcd  = '{tens: min_tens, ones: min_ones};
  assign hr_bcd   = '{tens: hr_tens,  ones: hr_ones};
  assign hr12_bcd = hour_to_12h(hr_bcd);
  assign mode     = disp_state_e'(state);

  always_comb begin
    twelve_hr = 1'b0;
    page_two  = 1'b0;
    unique case (mode)
      STAT_12_ONE: twelve_hr = 1'b1;
      STAT_12_TWO: begin
        twelve_hr = 1'b1;
        page_two  = 1'b1;
      end
      STAT_24_ONE: twelve_hr = 1'b0;
      STAT_24_TWO: page_two  = 1'b1;
      default: begin
        twelve_hr = 1'b0;
        page_two  = 1'b0;
      end
    endcase
  end

  // PM stays live on the MM:SS page so the indicator does not flicker on page flips.
  always_comb begin
    hr_shown = hr_bcd;
    pm_next  = 1'b0;
    if (twelve_hr) begin
      hr_shown = hr12_bcd;
      pm_next  = hour_is_pm(hr_bcd);
      if (LEADING_BLANK && hr12_bcd.tens == 4'd0) begin
        hr_shown.tens = BLANK_CODE;
      end
    end
    if (page_two) begin
      digits_next = {min_bcd, sec_bcd};
    end else begin
      digits_next = {hr_shown, min_bcd};
    end
  end

  // Reset image is 12:00 so a freshly reset 12 h display looks like midnight, not blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit3 <= 4'd1;
      digit2 <= 4'd2;
      digit1 <= 4'd0;
      digit0 <= 4'd0;
      pm     <= 1'b0;
    end else begin
      digit3 <= digits_next[15:12];
      digit2 <= digits_next[11:8];
      digit1 <= digits_next[7:4];
      digit0 <= digits_next[3:0];
      pm     <= pm_next;
    end
  end

endmodule

// File: tb/tb_time_display_ctrl.sv
// Scoreboard bench for time_display_ctrl: a time-of-day model predicts every
// registered display word, checked against a blanking and a non-blanking DUT.
module tb_time_display_ctrl;

  localparam logic [1:0] S12_ONE = 2'b00;
  localparam logic [1:0] S12_TWO = 2'b01;
  localparam logic [1:0] S24_ONE = 2'b10;
  localparam logic [1:0] S24_TWO = 2'b11;

  typedef struct {
    logic [16:0] main;
    logic [16:0] nb;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  logic       tick;
  logic       inc_hr;
  logic       inc_min;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       pm;
  logic [3:0] nb_digit3, nb_digit2, nb_digit1, nb_digit0;
  logic       nb_pm;

  int   tests_run;
  int   tests_failed;
  int   m_hr, m_min, m_sec;
  exp_t exp_q[$];

  time_display_ctrl dut (
    .clk(clk), .rst_n(rst_n), .state(state), .tick(tick),
    .inc_hr(inc_hr), .inc_min(inc_min),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0), .pm(pm)
  );

  time_display_ctrl #(.LEADING_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .state(state), .tick(tick),
    .inc_hr(inc_hr), .inc_min(inc_min),
    .digit3(nb_digit3), .digit2(nb_digit2), .digit1(nb_digit1), .digit0(nb_digit0), .pm(nb_pm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display word {pm, d3, d2, d1, d0} from plain integer time.
  function automatic logic [16:0] fmt(int h, int m, int s, logic [1:0] st, bit lb);
    int hd;
    logic [3:0] ht, ho;
    logic p;
    if (st[1]) begin
      hd = h;
      p  = 1'b0;
    end else begin
      hd = (h % 12 == 0) ? 12 : h % 12;
      p  = (h >= 12);
    end
    ht = 4'(hd / 10);
    ho = 4'(hd % 10);
    if (!st[1] && ht == 4'd0 && lb) ht = 4'hF;
    if (st[0]) return {p, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    return {p, ht, ho, 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [16:0] now_main();
    return {pm, digit3, digit2, digit1, digit0};
  endfunction

  function automatic logic [16:0] now_nb();
    return {nb_pm, nb_digit3, nb_digit2, nb_digit1, nb_digit0};
  endfunction

  task automatic checkOutput(input string tag, input logic [16:0] got, input logic [16:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got pm/digits %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the prediction for this edge is queued before the model advances.
  task automatic applyStimulus(input logic t, input logic ih, input logic im, input logic [1:0] st);
    exp_t e;
    @(negedge clk);
    tick = t; inc_hr = ih; inc_min = im; state = st;
    e.main = fmt(m_hr, m_min, m_sec, st, 1'b1);
    e.nb   = fmt(m_hr, m_min, m_sec, st, 1'b0);
    exp_q.push_back(e);
    if (ih) m_hr = (m_hr + 1) % 24;
    if (im) m_min = (m_min + 1) % 60;
    if (t && !ih && !im) begin
      m_sec++;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min++;
        if (m_min == 60) begin
          m_min = 0;
          m_hr = (m_hr + 1) % 24;
        end
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput("queue_empty", 17'h1FFFF, 17'h0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("disp", now_main(), e.main);
      checkOutput("disp_noblank", now_nb(), e.nb);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    m_hr = 0; m_min = 0; m_sec = 0;
    tick = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; state = S12_ONE;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_value", now_main(), 17'h01200);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 0, 0, S12_ONE);
    checkOutput("t1_12_one", now_main(), 17'h01200);
    applyStimulus(0, 0, 0, S24_ONE);
    checkOutput("t1_24_one", now_main(), 17'h00000);

    for (int i = 0; i < 23; i++) applyStimulus(0, 1, 0, S24_TWO);
    for (int i = 0; i < 59; i++) applyStimulus(0, 0, 1, S24_TWO);
    for (int i = 0; i < 59; i++) applyStimulus(1, 0, 0, S24_TWO);
    applyStimulus(0, 0, 0, S24_TWO);
    checkOutput("t2_235959", now_main(), 17'h05959);
    applyStimulus(1, 0, 0, S24_TWO);
    applyStimulus(0, 0, 0, S24_TWO);
    checkOutput("t2_rollover_two", now_main(), 17'h00000);
    applyStimulus(0, 0, 0, S24_ONE);
    checkOutput("t2_rollover_one", now_main(), 17'h00000);

    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, S12_ONE);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, S12_ONE);
    applyStimulus(0, 0, 0, S12_ONE);
    checkOutput("t3_1305_blank", now_main(), 17'h1F105);
    checkOutput("t3_1305_noblank", now_nb(), 17'h10105);
    for (int i = 0; i < 23; i++) applyStimulus(0, 1, 0, S12_ONE);
    applyStimulus(0, 0, 0, S12_ONE);
    checkOutput("t3_noon", now_main(), 17'h11205);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, S12_ONE);
    applyStimulus(0, 0, 0, S12_ONE);
    checkOutput("t3_midnight", now_main(), 17'h01205);

    for (int i = 0; i < 54; i++) applyStimulus(0, 0, 1, S24_TWO);
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, S24_TWO);
    applyStimulus(1, 0, 1, S24_TWO);
    applyStimulus(0, 0, 0, S24_TWO);
    checkOutput("t4_tick_dropped", now_main(), 17'h00030);
    applyStimulus(0, 0, 0, S24_ONE);
    checkOutput("t4_no_hr_carry", now_main(), 17'h00000);

    for (int i = 0; i < 57; i++) applyStimulus(1, 0, 0, S24_TWO);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, S24_TWO);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, S24_ONE);
    applyStimulus(0, 0, 0, S12_ONE);
    checkOutput("t5_12_one", now_main(), 17'h0F941);
    applyStimulus(0, 0, 0, S12_TWO);
    checkOutput("t5_12_two", now_main(), 17'h04127);
    applyStimulus(0, 0, 0, S24_ONE);
    checkOutput("t5_24_one", now_main(), 17'h00941);
    applyStimulus(0, 0, 0, S24_TWO);
    checkOutput("t5_24_two", now_main(), 17'h04127);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, S24_TWO);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset", now_main(), 17'h01200);
    checkOutput("t6_async_reset_nb", now_nb(), 17'h01200);
    tick = 1'b0;
    exp_q.delete();
    m_hr = 0; m_min = 0; m_sec = 0;
    repeat (2) @(negedge clk);
    checkOutput("t6_reset_held", now_main(), 17'h01200);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, S24_TWO);
    applyStimulus(0, 0, 0, S24_TWO);
    checkOutput("t6_resume", now_main(), 17'h00003);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
